// File: rtl/rf_write_arbiter_if.sv
// Signal bundle for the register-file write arbiter: A/M result channels,
// the registered write port, decode forwarding lookups and the busy flag.
interface rf_write_arbiter_if #(
  parameter int INDEX_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH  = 32
);
  logic                       a_valid;
  logic                       a_ready;
  logic [INDEX_BIT_WIDTH-1:0] a_index;
  logic [DATA_BIT_WIDTH-1:0]  a_data;
  logic                       m_valid;
  logic [INDEX_BIT_WIDTH-1:0] m_index;
  logic [DATA_BIT_WIDTH-1:0]  m_data;
  logic                       wrtEn;
  logic [INDEX_BIT_WIDTH-1:0] wrtIndex;
  logic [DATA_BIT_WIDTH-1:0]  dataIn;
  logic [INDEX_BIT_WIDTH-1:0] rdIndex1;
  logic [INDEX_BIT_WIDTH-1:0] rdIndex2;
  logic                       fwd_hit1;
  logic                       fwd_hit2;
  logic [DATA_BIT_WIDTH-1:0]  fwd_data1;
  logic [DATA_BIT_WIDTH-1:0]  fwd_data2;
  logic                       busy;

  modport slave (
    input  a_valid, a_index, a_data, m_valid, m_index, m_data, rdIndex1, rdIndex2,
    output a_ready, wrtEn, wrtIndex, dataIn, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, busy
  );

  modport master (
    output a_valid, a_index, a_data, m_valid, m_index, m_data, rdIndex1, rdIndex2,
    input  a_ready, wrtEn, wrtIndex, dataIn, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, busy
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Single register-file write port shared by the unstallable M source (priority)
// and the stallable A source, whose overflow waits in a small in-order queue.
module rf_write_arbiter #(
  parameter int DEPTH           = 2,
  parameter int INDEX_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH  = 32
) (
  input logic              clk,
  input logic              reset,
  rf_write_arbiter_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t LAST_PTR = ptr_t'(DEPTH - 1);
  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
  localparam logic [PTR_W:0] DEPTH_W = (PTR_W + 1)'(DEPTH);

  logic [INDEX_BIT_WIDTH-1:0] qIndexR [DEPTH];
  logic [DATA_BIT_WIDTH-1:0]  qDataR  [DEPTH];
  ptr_t                       headR;
  ptr_t                       tailR;
  cnt_t                       countR;
  logic                       wrtEnR;
  logic [INDEX_BIT_WIDTH-1:0] wrtIndexR;
  logic [DATA_BIT_WIDTH-1:0]  dataInR;

  logic                       aReadyS;
  logic                       aFireS;
  logic                       pushS;
  logic                       popS;
  cnt_t                       nextCountS;
  logic                       nextWrtEnS;
  logic [INDEX_BIT_WIDTH-1:0] nextIndexS;
  logic [DATA_BIT_WIDTH-1:0]  nextDataS;

  logic [INDEX_BIT_WIDTH-1:0] rdS   [2];
  logic                       hitS  [2];
  logic [DATA_BIT_WIDTH-1:0]  fwdS  [2];
  logic [PTR_W:0]             sumS;
  ptr_t                       slotS;
  logic                       matchS;

  function automatic ptr_t nextPtr(input ptr_t p);
    if (p == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + ptr_t'(1'b1);
    end
  endfunction

  assign aReadyS = (countR < DEPTH_C);
  assign aFireS  = bus.a_valid & aReadyS;

  // Port selection: M first, then queue head, then a bypassing A transfer.
  always_comb begin
    pushS      = 1'b0;
    popS       = 1'b0;
    nextWrtEnS = 1'b0;
    nextIndexS = wrtIndexR;
    nextDataS  = dataInR;
    if (bus.m_valid) begin
      nextWrtEnS = 1'b1;
      nextIndexS = bus.m_index;
      nextDataS  = bus.m_data;
      pushS      = aFireS;
    end else if (countR != {CNT_W{1'b0}}) begin
      nextWrtEnS = 1'b1;
      nextIndexS = qIndexR[headR];
      nextDataS  = qDataR[headR];
      popS       = 1'b1;
      pushS      = aFireS;
    end else if (aFireS) begin
      nextWrtEnS = 1'b1;
      nextIndexS = bus.a_index;
      nextDataS  = bus.a_data;
    end else begin
      nextWrtEnS = 1'b0;
    end
  end

  // Occupancy update from the push/pop pair.
  always_comb begin
    case ({pushS, popS})
      2'b10:   nextCountS = countR + cnt_t'(1'b1);
      2'b01:   nextCountS = countR - cnt_t'(1'b1);
      default: nextCountS = countR;
    endcase
  end

  // Queue storage, pointers and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      headR     <= {PTR_W{1'b0}};
      tailR     <= {PTR_W{1'b0}};
      countR    <= {CNT_W{1'b0}};
      wrtEnR    <= 1'b0;
      wrtIndexR <= {INDEX_BIT_WIDTH{1'b0}};
      dataInR   <= {DATA_BIT_WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        qIndexR[i] <= {INDEX_BIT_WIDTH{1'b0}};
        qDataR[i]  <= {DATA_BIT_WIDTH{1'b0}};
      end
    end else begin
      if (pushS) begin
        qIndexR[tailR] <= bus.a_index;
        qDataR[tailR]  <= bus.a_data;
        tailR          <= nextPtr(tailR);
      end
      if (popS) begin
        headR <= nextPtr(headR);
      end
      countR    <= nextCountS;
      wrtEnR    <= nextWrtEnS;
      wrtIndexR <= nextIndexS;
      dataInR   <= nextDataS;
    end
  end

  assign rdS[0] = bus.rdIndex1;
  assign rdS[1] = bus.rdIndex2;

  // Forwarding: seed with the write port, then walk the queue oldest to
  // youngest so the youngest match ends up winning.
  always_comb begin
    sumS   = {(PTR_W + 1){1'b0}};
    slotS  = {PTR_W{1'b0}};
    matchS = 1'b0;
    for (int p = 0; p < 2; p++) begin
      matchS  = wrtEnR & (wrtIndexR == rdS[p]);
      hitS[p] = matchS;
      fwdS[p] = matchS ? dataInR : {DATA_BIT_WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        sumS    = {1'b0, headR} + (PTR_W + 1)'(i);
        sumS    = (sumS >= DEPTH_W) ? (sumS - DEPTH_W) : sumS;
        slotS   = sumS[PTR_W-1:0];
        matchS  = (cnt_t'(i) < countR) & (qIndexR[slotS] == rdS[p]);
        hitS[p] = hitS[p] | matchS;
        fwdS[p] = matchS ? qDataR[slotS] : fwdS[p];
      end
    end
  end

  assign bus.a_ready   = aReadyS;
  assign bus.wrtEn     = wrtEnR;
  assign bus.wrtIndex  = wrtIndexR;
  assign bus.dataIn    = dataInR;
  assign bus.busy      = (countR != {CNT_W{1'b0}}) | wrtEnR;
  assign bus.fwd_hit1  = hitS[0];
  assign bus.fwd_hit2  = hitS[1];
  assign bus.fwd_data1 = fwdS[0];
  assign bus.fwd_data2 = fwdS[1];
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected writes are queued per source
// when stimulus is accepted and checked as the write port produces them.
module tb_rf_write_arbiter;
  localparam int DEPTH = 2;
  localparam int IW    = 4;
  localparam int DW    = 32;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.INDEX_BIT_WIDTH(IW), .DATA_BIT_WIDTH(DW)) bus ();

  rf_write_arbiter #(.DEPTH(DEPTH), .INDEX_BIT_WIDTH(IW), .DATA_BIT_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wr_t aExp[$];
  wr_t mExp[$];
  int  checks = 0;
  int  fails  = 0;
  bit  mLast  = 1'b0;
  bit  monEn  = 1'b0;
  bit  lastAcc = 1'b0;

  // One clock: record accepted stimulus in the scoreboard, then advance.
  task automatic step();
    bit mNow, acc, rstNow;
    rstNow = reset;
    mNow = bus.m_valid && !reset;
    acc  = bus.a_valid && bus.a_ready && !reset;
    if (mNow) mExp.push_back({bus.m_index, bus.m_data});
    if (acc)  aExp.push_back({bus.a_index, bus.a_data});
    @(posedge clk);
    mLast   = mNow;
    lastAcc = acc;
    if (rstNow) aExp.delete();
    #1;
  endtask

  task automatic idle();
    bus.a_valid = 1'b0;
    bus.m_valid = 1'b0;
  endtask

  // Write-port monitor: M results must appear the cycle after they are driven.
  always @(negedge clk) begin
    if (monEn && (mLast || bus.wrtEn)) begin
      wr_t e;
      checks++;
      if (!bus.wrtEn) begin
        fails++;
        $display("FAIL m_write_missing: wrtEn=%0b required 1", bus.wrtEn);
      end else if (mLast) begin
        if (mExp.size() == 0) begin
          fails++;
          $display("FAIL m_scoreboard_empty: write %h/%h with no expected M", bus.wrtIndex, bus.dataIn);
        end else begin
          e = mExp.pop_front();
          if ({bus.wrtIndex, bus.dataIn} !== e) begin
            fails++;
            $display("FAIL m_write: got %h/%h required %h/%h", bus.wrtIndex, bus.dataIn, e.idx, e.data);
          end
        end
      end else if (aExp.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got %h/%h with no pending A", bus.wrtIndex, bus.dataIn);
      end else begin
        e = aExp.pop_front();
        if ({bus.wrtIndex, bus.dataIn} !== e) begin
          fails++;
          $display("FAIL a_write_order: got %h/%h required %h/%h", bus.wrtIndex, bus.dataIn, e.idx, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    checks++;
    if ({bus.wrtEn, bus.wrtIndex, bus.dataIn, bus.busy, bus.a_ready} !== {1'b0, 4'h0, 32'h0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: wrtEn=%b idx=%h data=%h busy=%b a_ready=%b", bus.wrtEn, bus.wrtIndex, bus.dataIn, bus.busy, bus.a_ready);
    end
    reset = 1'b0;
    monEn = 1'b1;
  endtask

  task automatic test_single_a();
    bus.a_valid = 1'b1; bus.a_index = 4'd3; bus.a_data = 32'h11;
    step();
    idle();
    checks++;
    if ({bus.wrtEn, bus.wrtIndex, bus.dataIn} !== {1'b1, 4'd3, 32'h11}) begin
      fails++;
      $display("FAIL single_a_latency: got %b/%h/%h required 1/3/11", bus.wrtEn, bus.wrtIndex, bus.dataIn);
    end
    step();
    checks++;
    if ({bus.wrtEn, bus.busy} !== 2'b00) begin
      fails++;
      $display("FAIL single_a_idle: wrtEn/busy=%b%b required 00", bus.wrtEn, bus.busy);
    end
  endtask

  task automatic test_m_priority();
    bus.m_valid = 1'b1; bus.m_index = 4'd5; bus.m_data = 32'hAA;
    bus.a_valid = 1'b1; bus.a_index = 4'd6; bus.a_data = 32'hBB;
    step();
    idle();
    checks++;
    if ({bus.wrtEn, bus.wrtIndex, bus.dataIn, bus.busy} !== {1'b1, 4'd5, 32'hAA, 1'b1}) begin
      fails++;
      $display("FAIL m_priority_first: got %b/%h/%h busy=%b required 1/5/aa busy=1", bus.wrtEn, bus.wrtIndex, bus.dataIn, bus.busy);
    end
    step();
    checks++;
    if ({bus.wrtEn, bus.wrtIndex, bus.dataIn} !== {1'b1, 4'd6, 32'hBB}) begin
      fails++;
      $display("FAIL m_priority_second: got %b/%h/%h required 1/6/bb", bus.wrtEn, bus.wrtIndex, bus.dataIn);
    end
    step();
    checks++;
    if ({bus.wrtEn, bus.busy} !== 2'b00) begin
      fails++;
      $display("FAIL m_priority_drain: wrtEn/busy=%b%b required 00", bus.wrtEn, bus.busy);
    end
  endtask

  task automatic test_full_queue();
    int k;
    bit expReady;
    k = 1;
    for (int c = 0; c < 6; c++) begin
      bus.m_valid = (c < 4);
      bus.m_index = 4'(8 + c); bus.m_data = 32'h200 + 32'(c);
      bus.a_valid = (k <= 3);
      bus.a_index = 4'(k); bus.a_data = 32'h100 + 32'(k);
      expReady = (c < 2) || (c == 5);
      checks++;
      if (bus.a_ready !== expReady) begin
        fails++;
        $display("FAIL full_a_ready: cycle %0d got %b required %b", c, bus.a_ready, expReady);
      end
      step();
      if (lastAcc) k++;
      if (c >= 4) begin
        checks++;
        if ({bus.wrtEn, bus.wrtIndex, bus.dataIn} !== {1'b1, 4'(c - 3), 32'h100 + 32'(c - 3)}) begin
          fails++;
          $display("FAIL full_order: cycle %0d got %b/%h/%h required 1/%0d", c, bus.wrtEn, bus.wrtIndex, bus.dataIn, c - 3);
        end
      end
    end
    idle();
    step();
    checks++;
    if ({bus.wrtEn, bus.wrtIndex, bus.dataIn} !== {1'b1, 4'd3, 32'h103}) begin
      fails++;
      $display("FAIL full_last: got %b/%h/%h required 1/3/103", bus.wrtEn, bus.wrtIndex, bus.dataIn);
    end
    step();
    checks++;
    if ({bus.wrtEn, bus.busy} !== 2'b00) begin
      fails++;
      $display("FAIL full_drain: wrtEn/busy=%b%b required 00", bus.wrtEn, bus.busy);
    end
  endtask

  task automatic test_forwarding();
    bus.m_valid = 1'b1; bus.m_index = 4'd12; bus.m_data = 32'hC0;
    bus.a_valid = 1'b1; bus.a_index = 4'd7; bus.a_data = 32'h1;
    step();
    bus.m_data = 32'hC1; bus.a_data = 32'h2;
    step();
    bus.a_valid = 1'b0; bus.m_data = 32'hC2;
    bus.rdIndex1 = 4'd7; bus.rdIndex2 = 4'd9;
    #1;
    checks++;
    if ({bus.fwd_hit1, bus.fwd_data1, bus.fwd_hit2, bus.fwd_data2} !== {1'b1, 32'h2, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL fwd_youngest: hit1=%b d1=%h hit2=%b d2=%h required 1/2 0/0", bus.fwd_hit1, bus.fwd_data1, bus.fwd_hit2, bus.fwd_data2);
    end
    bus.rdIndex2 = 4'd12;
    #1;
    checks++;
    if ({bus.fwd_hit2, bus.fwd_data2} !== {1'b1, 32'hC1}) begin
      fails++;
      $display("FAIL fwd_write_port_m: hit2=%b d2=%h required 1/c1", bus.fwd_hit2, bus.fwd_data2);
    end
    step();
    idle();
    step();
    checks++;
    if ({bus.wrtIndex, bus.fwd_hit1, bus.fwd_data1} !== {4'd7, 1'b1, 32'h2}) begin
      fails++;
      $display("FAIL fwd_queue_over_port: idx=%h hit1=%b d1=%h required 7/1/2", bus.wrtIndex, bus.fwd_hit1, bus.fwd_data1);
    end
    step();
    checks++;
    if ({bus.fwd_hit1, bus.fwd_data1} !== {1'b1, 32'h2}) begin
      fails++;
      $display("FAIL fwd_port_after_pop: hit1=%b d1=%h required 1/2", bus.fwd_hit1, bus.fwd_data1);
    end
    step();
    checks++;
    if ({bus.fwd_hit1, bus.fwd_data1} !== {1'b0, 32'h0}) begin
      fails++;
      $display("FAIL fwd_idle_miss: hit1=%b d1=%h required 0/0", bus.fwd_hit1, bus.fwd_data1);
    end
  endtask

  task automatic test_write_port_fwd();
    bus.a_valid = 1'b1; bus.a_index = 4'd4; bus.a_data = 32'h55;
    step();
    idle();
    bus.rdIndex1 = 4'd4;
    #1;
    checks++;
    if ({bus.fwd_hit1, bus.fwd_data1} !== {1'b1, 32'h55}) begin
      fails++;
      $display("FAIL fwd_write_port: hit1=%b d1=%h required 1/55", bus.fwd_hit1, bus.fwd_data1);
    end
    step();
  endtask

  task automatic test_reset_full();
    bus.m_valid = 1'b1; bus.m_index = 4'd13; bus.m_data = 32'hD0;
    bus.a_valid = 1'b1; bus.a_index = 4'd1;  bus.a_data = 32'hA1;
    step();
    bus.m_index = 4'd14; bus.m_data = 32'hD1; bus.a_index = 4'd2; bus.a_data = 32'hA2;
    step();
    reset = 1'b1;
    bus.m_index = 4'd15; bus.m_data = 32'hD2; bus.a_index = 4'd3; bus.a_data = 32'hA3;
    step();
    reset = 1'b0;
    idle();
    checks++;
    if ({bus.wrtEn, bus.busy, bus.a_ready} !== 3'b001) begin
      fails++;
      $display("FAIL reset_full: wrtEn/busy/a_ready=%b%b%b required 001", bus.wrtEn, bus.busy, bus.a_ready);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_full_quiet: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int waited;
    for (int i = 0; i < 40; i++) begin
      bus.m_valid = ($urandom_range(0, 2) == 0);
      bus.m_index = 4'($urandom_range(0, 15)); bus.m_data = $urandom;
      bus.a_valid = ($urandom_range(0, 3) != 0);
      bus.a_index = 4'($urandom_range(0, 15)); bus.a_data = $urandom;
      step();
    end
    idle();
    waited = 0;
    while (bus.busy === 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || aExp.size() != 0 || mExp.size() != 0) begin
      fails++;
      $display("FAIL b2b_drain: busy=%b pendingA=%0d pendingM=%0d required 0/0/0", bus.busy, aExp.size(), mExp.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.a_valid = 1'b0; bus.a_index = 4'd0; bus.a_data = 32'h0;
    bus.m_valid = 1'b0; bus.m_index = 4'd0; bus.m_data = 32'h0;
    bus.rdIndex1 = 4'd0; bus.rdIndex2 = 4'd0;
    test_reset();
    test_single_a();
    test_m_priority();
    test_full_queue();
    test_forwarding();
    test_write_port_fwd();
    test_reset_full();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single write port of the pipeline's 16 x 32 register file.
- Merges two result sources into one write per cycle:
  - ALU writeback (A), which can be stalled.
  - Long-latency unit writeback (M), which cannot be stalled and always has priority.
- Stalled A results wait in a small in-order queue.
- A forwarding lookup lets decode see values not yet written into the register file.

Parameters:
- DEPTH, 2, number of A-result queue entries (1..4).
- INDEX_BIT_WIDTH, 4, register index width.
- DATA_BIT_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  ALU result offered this cycle.
- a_ready  out  1  queue can accept an A result this cycle.
- a_index  in  INDEX_BIT_WIDTH  A destination register.
- a_data  in  DATA_BIT_WIDTH  A result value.
- m_valid  in  1  long-latency result this cycle; must be accepted.
- m_index  in  INDEX_BIT_WIDTH  M destination register.
- m_data  in  DATA_BIT_WIDTH  M result value.
- wrtEn  out  1  register file write enable (registered).
- wrtIndex  out  INDEX_BIT_WIDTH  register file write index (registered).
- dataIn  out  DATA_BIT_WIDTH  register file write data (registered).
- rdIndex1, rdIndex2  in  INDEX_BIT_WIDTH  decode read indices.
- fwd_hit1, fwd_hit2  out  1  a pending value exists for that read index.
- fwd_data1, fwd_data2  out  DATA_BIT_WIDTH  forwarded value.
- busy  out  1  queue non-empty or wrtEn high.

Behaviour:
- Reset, synchronous, active-high:
  - wrtEn=0, wrtIndex=0, dataIn=0.
  - Queue emptied (count=0, head/tail pointers=0).
  - a_ready=1 after the reset cycle; busy=0.
  - Reset overrides any same-cycle a_valid or m_valid; those results are dropped.
- a_ready = (count < DEPTH). It is combinational from count only and does not depend on m_valid.
- A transfer occurs when a_valid & a_ready. The entry is pushed at the queue tail.
- Port selection each cycle, registered onto wrtEn/wrtIndex/dataIn at the next edge:
  - If m_valid: the M result is written. The queue does not pop.
  - Else if the queue is non-empty: the head is popped and written.
  - Else if an A transfer occurs this cycle: it bypasses the queue and is written directly. There is no push.
  - Else: wrtEn=0. wrtIndex and dataIn hold their last values.
- Latency (cycles from input to wrtEn=1):
  - M result with empty queue: 1 cycle.
  - A result with queue empty and m_valid=0: 1 cycle.
- Simultaneous push and pop: count is unchanged and pointers wrap modulo DEPTH.
- Full queue with m_valid=1 for consecutive cycles: a_ready stays 0 and the queue holds its contents. There is no overflow and no loss.
- Write ordering: A results are written strictly in acceptance order. Issue logic guarantees that M and pending A results never target the same register, so no inter-source ordering is enforced.
- Forwarding for each read port, combinational, first match wins:
  1. Youngest queue entry with matching index.
  2. Older queue entries.
  3. Registered write port when wrtEn=1 and wrtIndex matches.
  - On a match: fwd_hit=1 and fwd_data is the matching value.
  - No match: fwd_hit=0 and fwd_data=0.
- Register 0 has no special treatment.
- busy = (count != 0) | wrtEn.

Test Plan:
- Reset, then a_valid=1, a_index=3, a_data=0x11, m_valid=0 for one cycle -> next cycle wrtEn=1, wrtIndex=3, dataIn=0x11; the following cycle wrtEn=0 and busy=0.
- Same cycle: m_valid=1 (idx 5, 0xAA) and a_valid=1 (idx 6, 0xBB) -> cycle+1 writes 5/0xAA; cycle+2 writes 6/0xBB; count returns to 0.
- Hold m_valid=1 for 4 cycles while offering A results 1,2,3 with DEPTH=2 -> a_ready drops after 2 pushes; result 3 is held by its source; after m_valid drops, writes occur in order 1,2,3, one per cycle.
- Queue holds idx 7=0x1 (older) and idx 7=0x2 (younger), rdIndex1=7 -> fwd_hit1=1, fwd_data1=0x2. With rdIndex2=9 -> fwd_hit2=0, fwd_data2=0.
- wrtEn=1, wrtIndex=4, dataIn=0x55, empty queue, rdIndex1=4 -> fwd_hit1=1, fwd_data1=0x55.
- Queue full, assert reset with a_valid=1 and m_valid=1 -> next cycle wrtEn=0, busy=0, a_ready=1; no dropped entry is ever written.
